// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event request / stretched output bundle for pulse_stretcher
interface pulse_stretcher_if #(
  parameter int QUEUE_DEPTH = 4
);
  localparam int PW = $clog2(QUEUE_DEPTH + 1);

  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  // control logic side: raises events, observes the blinker
  modport master (
    output pulse_in,
    input  led_out,
    input  busy,
    input  pending,
    input  dropped
  );

  // blinker side
  modport slave (
    input  pulse_in,
    output led_out,
    output busy,
    output pending,
    output dropped
  );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - event pulse to fixed blink + gap stretcher; PULSE_QUEUE_EN enables the event replay queue
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 20_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pulse_stretcher_if.slave  bus
);

  localparam int PW   = $clog2(QUEUE_DEPTH + 1);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          led_q;
  logic          dropped_q;
  logic          pulse_in_q;
  logic          ev;

`ifdef PULSE_QUEUE_EN
  localparam logic [PW-1:0] Q_FULL = PW'(QUEUE_DEPTH);
  logic [PW-1:0] pending_q;
`endif

  // pulse_in_q resets high so a level held through reset does not count as an event
  assign ev = bus.pulse_in & ~pulse_in_q;

  // blink sequencer: edge history, hold/gap timing, replay queue and drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      led_q      <= 1'b0;
      dropped_q  <= 1'b0;
      pulse_in_q <= 1'b1;
`ifdef PULSE_QUEUE_EN
      pending_q  <= '0;
`endif
    end else begin
      pulse_in_q <= bus.pulse_in;
      dropped_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (ev) begin
            state <= HOLD;
            led_q <= 1'b1;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= GAP;
            led_q <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (ev) begin
`ifdef PULSE_QUEUE_EN
            if (pending_q == Q_FULL) dropped_q <= 1'b1;
            else                     pending_q <= pending_q + 1'b1;
`else
            dropped_q <= 1'b1;
`endif
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
`ifdef PULSE_QUEUE_EN
            // an event landing on the final gap cycle replays directly, leaving pending as is
            if ((pending_q != '0) || ev) begin
              state <= HOLD;
              led_q <= 1'b1;
              if (!ev) pending_q <= pending_q - 1'b1;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
            if (ev) dropped_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            if (ev) begin
`ifdef PULSE_QUEUE_EN
              if (pending_q == Q_FULL) dropped_q <= 1'b1;
              else                     pending_q <= pending_q + 1'b1;
`else
              dropped_q <= 1'b1;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          led_q <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.led_out = led_q;
  assign bus.busy    = (state != IDLE);
  assign bus.dropped = dropped_q;
`ifdef PULSE_QUEUE_EN
  assign bus.pending = pending_q;
`else
  assign bus.pending = PW'(0);
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - randomized self-checking bench for pulse_stretcher against a blink-schedule model
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pulse_stretcher_if #(.QUEUE_DEPTH(QD)) bus ();

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int n      = 0;
  bit armed  = 0;

  // model: sample index of every blink's first high cycle, and the subset that came from the queue
  int starts[$];
  int queued[$];
  bit prev_p    = 1'b1;
  int drop_edge = -10;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === 32'(exp_v)) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp_v);
    end
  endtask

  task automatic model_edge(input bit p, input bit r);
    bit ev;
    bit busy_now;
    int cnt_q;
    bit dec_now;
    bit final_tail;
    int s;
    if (r) begin
      starts.delete();
      queued.delete();
      prev_p    = 1'b1;
      drop_edge = -10;
      return;
    end
    ev     = p && !prev_p;
    prev_p = p;
    if (!ev) return;
    busy_now = (starts.size() > 0) && (n <= starts[$] + H + G - 1);
    if (!busy_now) begin
      starts.push_back(n + 1);
    end else begin
`ifdef PULSE_QUEUE_EN
      cnt_q   = 0;
      dec_now = 1'b0;
      foreach (queued[i]) begin
        if (queued[i] > n)      cnt_q++;
        if (queued[i] == n + 1) dec_now = 1'b1;
      end
      final_tail = (n == starts[$] + H + G - 1);
      if (dec_now || final_tail || cnt_q < QD) begin
        s = starts[$] + H + G;
        starts.push_back(s);
        queued.push_back(s);
      end else begin
        drop_edge = n;
      end
`else
      cnt_q = 0; dec_now = 1'b0; final_tail = 1'b0; s = 0;
      drop_edge = n;
`endif
    end
  endtask

  task automatic step(input bit p, input bit r);
    int e_led;
    int e_busy;
    int e_pend;
    int e_drop;
    @(negedge clk);
    if (armed) begin
      while (starts.size() > 1 && starts[0] + H + G < n) void'(starts.pop_front());
      while (queued.size() > 0 && queued[0] < n) void'(queued.pop_front());
      e_led  = 0;
      e_busy = 0;
      e_pend = 0;
      foreach (starts[i]) begin
        if (starts[i] <= n && n <= starts[i] + H - 1)     e_led  = 1;
        if (starts[i] <= n && n <= starts[i] + H + G - 1) e_busy = 1;
      end
      foreach (queued[i]) if (queued[i] > n) e_pend++;
      e_drop = (drop_edge == n - 1) ? 1 : 0;
      chk("led_out", 32'(bus.led_out), e_led);
      chk("busy",    32'(bus.busy),    e_busy);
      chk("pending", 32'(bus.pending), e_pend);
      chk("dropped", 32'(bus.dropped), e_drop);
    end
    bus.pulse_in = p;
    rst          = r;
    model_edge(p, r);
    if (r) armed = 1'b1;
    n++;
  endtask

  initial begin
    int thresh;
    bus.pulse_in = 1'b0;
    step(0, 1);
    step(0, 1);

    // single event
    step(1, 0);
    repeat (10) step(0, 0);

    // level held high for many cycles: one blink only
    repeat (21) step(1, 0);
    repeat (10) step(0, 0);

    // events two cycles apart: queued replays
    for (int k = 0; k < 6; k++) step(k % 2 == 0, 0);
    repeat (20) step(0, 0);

    // dense events: overflow of the queue
    repeat (8) begin
      step(1, 0);
      step(0, 0);
    end
    repeat (30) step(0, 0);

    // reset mid-blink with pulse_in held high through and after reset
    step(1, 0);
    step(1, 0);
    step(1, 1);
    repeat (10) step(1, 0);
    repeat (12) step(0, 0);

    // randomized traffic with varying density and occasional resets
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       thresh = 1;
        1:       thresh = 5;
        default: thresh = 8;
      endcase
      step($urandom_range(0, 9) < thresh, $urandom_range(0, 299) == 0);
    end
    repeat (20) step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
